bypass_tracker: RTL and testbench
=================================

Name: bypass_tracker

Overview:
- Producer end of the wake-up/bypass interface. Tracks register-file writes in flight in EXE, MEM and WB, and drives the packed BY_to_WK_bus that the ID-stage wake-up logic consumes.
- Also supplies the forwarded operand value for both ID read ports.
- Holds one write-record per stage and shifts records along with the pipeline handshakes.

Parameters:
- DATA_WD, 32, register data width
- RADDR_WD, 5, register-file address width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_go  in  1  instruction leaves ID into EXE this cycle
- id_rf_w_en  in  1  ID instruction writes a register
- id_rf_w_addr  in  RADDR_WD  ID destination register
- exe_go  in  1  EXE contents move to MEM this cycle
- mem_go  in  1  MEM contents move to WB this cycle
- wb_go  in  1  WB contents retire this cycle
- exe_result_valid  in  1  EXE result computed this cycle
- exe_result  in  DATA_WD  EXE result
- mem_result_valid  in  1  MEM (load) data returned this cycle
- mem_result  in  DATA_WD  MEM data
- rd_addr1  in  RADDR_WD  ID read port 1 address
- rd_addr2  in  RADDR_WD  ID read port 2 address
- BY_to_WK_bus  out  `BY_TO_WK_BUS_WD (21)  packed write-record bus
- fwd_hit1  out  1  port-1 value comes from the pipeline
- fwd_data1  out  DATA_WD  forwarded port-1 value
- fwd_hit2  out  1  port-2 value comes from the pipeline
- fwd_data2  out  DATA_WD  forwarded port-2 value
- flush  in  1  only when BYPASS_FLUSH_EN is defined

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on resetn. On reset, all three records are cleared (valid, w_en, data_valid, addr and data all 0). Result: BY_to_WK_bus = 0, fwd_hit1 = fwd_hit2 = 0, fwd_data1 = fwd_data2 = 0.
- Record contents: valid, w_en, w_addr, data_valid, data.
- Zero register: a destination of 0 forces w_en = 0 on capture. r0 is never tracked.
- EXE record update:
  - on id_go: load {1, id_rf_w_en, id_rf_w_addr, 0, 0}
  - else on exe_go: clear
  - else hold; if exe_result_valid, latch data and set data_valid = 1
- MEM record update:
  - on exe_go: load the EXE record, with data/data_valid merged from exe_result when exe_result_valid
  - else on mem_go: clear
  - else hold; if mem_result_valid, latch data and set data_valid = 1
- WB record update:
  - on mem_go: load the MEM record, merged with mem_result when mem_result_valid
  - else on wb_go: clear
  - else hold
- Simultaneous events: a stage's go and an incoming load in the same cycle take the incoming record. Go with nothing incoming empties the stage.
- Effective data_valid per stage (combinational): stored data_valid OR that stage's *_result_valid. WB effective data_valid = valid (WB always holds final data).
- Bus packing, MSB to LSB:
  - EXE {w_addr, data_valid, w_en & valid} in [20:14]
  - MEM in [13:7]
  - WB in [6:0]
- Forwarding, per port:
  - hit = (addr != 0) and a stage matches with valid & w_en
  - priority EXE > MEM > WB
  - data = matched stage's live result if *_result_valid this cycle, else stored data
  - no match: hit = 0, data = 0
  - match on a stage whose data is not yet valid: hit = 1 and data is don't-care. Wake-up logic stalls on this case.
- Latency: a record is visible on the bus the cycle after id_go. Data produced in a cycle is visible combinationally in that same cycle.

Optional Feature:
- Macro: BYPASS_FLUSH_EN.
- When defined: flush port exists. flush = 1 clears the EXE and MEM records at the next edge, overriding id_go, exe_go and result latches. The WB record is unaffected and still loads from mem_go is suppressed.
- When undefined: no flush port; records change only via the go signals.

Decomposition:
- myCPU.h holds `BY_TO_WK_BUS_WD (21) and the field offsets: EXE_LSB 14, MEM_LSB 7, WB_LSB 0.
- One sub-module, bypass_stage_entry: a single record register with load/clear/result-latch inputs, instantiated three times.
- Forward muxing stays in the top level.

Test Plan:
- Reset: resetn = 0 for 2 cycles with all goes high -> bus = 21'h0, fwd_hit* = 0.
- ALU chain: id_go with r5; next cycle exe_result_valid = 1, exe_result = 32'h1234; rd_addr1 = 5 -> bus[20:14] = {5, 1, 1}, fwd_hit1 = 1, fwd_data1 = 32'h1234.
- Load stall: record r7 with no exe_result; exe_go; hold mem 2 cycles, then mem_result_valid with 32'hCAFE -> MEM field {7, 0, 1} for 2 cycles, then {7, 1, 1}, fwd_data2 = 32'hCAFE.
- Priority: r3 in EXE (data 32'hA) and in MEM (data 32'hB), rd_addr1 = 3 -> fwd_data1 = 32'hA.
- r0 write: id_go with id_rf_w_addr = 0 and w_en = 1 -> EXE w_en bit 0; rd_addr1 = 0 -> fwd_hit1 = 0.
- Flush (BYPASS_FLUSH_EN): EXE = r2, MEM = r4, WB = r6; assert flush -> next cycle only the WB field is nonzero, {6, 1, 1}.

Source files
------------

// File: rtl/bypass_tracker_pkg.sv
// ---------------------------------------------------------------------------
// bypass_tracker_pkg
//   Shared definitions for the bypass/wake-up producer. This file also
//   carries the contents of myCPU.h:
//     `BY_TO_WK_BUS_WD (21) and the field offsets EXE_LSB 14, MEM_LSB 7,
//     WB_LSB 0.
//   Optional feature macro used by the slice: BYPASS_FLUSH_EN.
// ---------------------------------------------------------------------------
`ifndef BY_TO_WK_BUS_WD
`define BY_TO_WK_BUS_WD 21
`endif

package bypass_tracker_pkg;

    // One bus field per stage: {w_addr, data_valid, w_en & valid}.
    localparam int BY_FIELD_WD = 7;
    localparam int EXE_LSB     = 14;
    localparam int MEM_LSB     = 7;
    localparam int WB_LSB      = 0;

    // Which pipeline stage supplies a forwarded operand.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXE  = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_WB   = 2'd3
    } fwd_src_e;

endpackage : bypass_tracker_pkg

// File: rtl/bypass_stage_entry.sv
// ---------------------------------------------------------------------------
// bypass_stage_entry
//   One in-flight register-write record (valid, w_en, w_addr, data_valid,
//   data). Priority: load > clear > result latch > hold.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   load, ld_*            capture an incoming record
//   clear                 empty the record
//   res_valid, res_data   latch a result produced while the record sits here
//   valid..data           current record contents
// ---------------------------------------------------------------------------
module bypass_stage_entry #(
    parameter int DATA_WD  = 32,
    parameter int RADDR_WD = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                ld_valid,
    input  logic                ld_w_en,
    input  logic [RADDR_WD-1:0] ld_w_addr,
    input  logic                ld_data_valid,
    input  logic [DATA_WD-1:0]  ld_data,
    input  logic                clear,
    input  logic                res_valid,
    input  logic [DATA_WD-1:0]  res_data,
    output logic                valid,
    output logic                w_en,
    output logic [RADDR_WD-1:0] w_addr,
    output logic                data_valid,
    output logic [DATA_WD-1:0]  data
);

    // NOTE: sequential state uses non-blocking assignments so every record
    // samples its neighbour's pre-edge value when the pipeline shifts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid      <= 1'b0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            data_valid <= 1'b0;
            data       <= '0;
        end else if (load) begin
            valid      <= ld_valid;
            // r0 is never tracked: a zero destination drops the write enable.
            w_en       <= ld_w_en && (ld_w_addr != '0);
            w_addr     <= ld_w_addr;
            data_valid <= ld_data_valid;
            data       <= ld_data;
        end else if (clear) begin
            valid      <= 1'b0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            data_valid <= 1'b0;
            data       <= '0;
        end else if (res_valid) begin
            data_valid <= 1'b1;
            data       <= res_data;
        end
    end

endmodule : bypass_stage_entry

// File: rtl/bypass_tracker.sv
// ---------------------------------------------------------------------------
// bypass_tracker
//   Producer end of the wake-up/bypass interface. Tracks register writes in
//   flight in EXE, MEM and WB, drives the packed BY_to_WK_bus for the ID
//   wake-up logic and supplies forwarded operands for both ID read ports.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   id_go, id_rf_w_en/addr       instruction entering EXE and its destination
//   exe_go, mem_go, wb_go        stage handshakes
//   exe_result(_valid)           EXE result produced this cycle
//   mem_result(_valid)           load data returned this cycle
//   rd_addr1, rd_addr2           ID read addresses
//   BY_to_WK_bus                 {EXE[20:14], MEM[13:7], WB[6:0]} records
//   fwd_hit*/fwd_data*           forwarded operand per read port
//   flush                        only with BYPASS_FLUSH_EN: kill EXE and MEM
// Optional feature macro: BYPASS_FLUSH_EN.
// ---------------------------------------------------------------------------
module bypass_tracker
    import bypass_tracker_pkg::*;
#(
    parameter int DATA_WD  = 32,
    parameter int RADDR_WD = 5
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          id_go,
    input  logic                          id_rf_w_en,
    input  logic [RADDR_WD-1:0]           id_rf_w_addr,
    input  logic                          exe_go,
    input  logic                          mem_go,
    input  logic                          wb_go,
    input  logic                          exe_result_valid,
    input  logic [DATA_WD-1:0]            exe_result,
    input  logic                          mem_result_valid,
    input  logic [DATA_WD-1:0]            mem_result,
    input  logic [RADDR_WD-1:0]           rd_addr1,
    input  logic [RADDR_WD-1:0]           rd_addr2,
    output logic [`BY_TO_WK_BUS_WD-1:0]   BY_to_WK_bus,
    output logic                          fwd_hit1,
    output logic [DATA_WD-1:0]            fwd_data1,
    output logic                          fwd_hit2,
    output logic [DATA_WD-1:0]            fwd_data2
`ifdef BYPASS_FLUSH_EN
    ,
    input  logic                          flush
`endif
);

    logic kill;
`ifdef BYPASS_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    logic                exe_valid, exe_w_en, exe_dv;
    logic [RADDR_WD-1:0] exe_w_addr;
    logic [DATA_WD-1:0]  exe_data;
    logic                mem_valid, mem_w_en, mem_dv;
    logic [RADDR_WD-1:0] mem_w_addr;
    logic [DATA_WD-1:0]  mem_data;
    logic                wb_valid, wb_w_en, wb_dv;
    logic [RADDR_WD-1:0] wb_w_addr;
    logic [DATA_WD-1:0]  wb_data;

    // Live view: a result produced this cycle counts as present data, both
    // for the bus/forward outputs and for the record handed to the next stage.
    logic                exe_eff_dv, mem_eff_dv, wb_eff_dv;
    logic [DATA_WD-1:0]  exe_live, mem_live;

    assign exe_eff_dv = exe_dv | exe_result_valid;
    assign mem_eff_dv = mem_dv | mem_result_valid;
    assign wb_eff_dv  = wb_valid;
    assign exe_live   = exe_result_valid ? exe_result : exe_data;
    assign mem_live   = mem_result_valid ? mem_result : mem_data;

    bypass_stage_entry #(.DATA_WD(DATA_WD), .RADDR_WD(RADDR_WD)) u_exe (
        .clk           (clk),
        .resetn        (resetn),
        .load          (id_go & ~kill),
        .ld_valid      (1'b1),
        .ld_w_en       (id_rf_w_en),
        .ld_w_addr     (id_rf_w_addr),
        .ld_data_valid (1'b0),
        .ld_data       ('0),
        .clear         (exe_go | kill),
        .res_valid     (exe_result_valid & ~kill),
        .res_data      (exe_result),
        .valid         (exe_valid),
        .w_en          (exe_w_en),
        .w_addr        (exe_w_addr),
        .data_valid    (exe_dv),
        .data          (exe_data)
    );

    bypass_stage_entry #(.DATA_WD(DATA_WD), .RADDR_WD(RADDR_WD)) u_mem (
        .clk           (clk),
        .resetn        (resetn),
        .load          (exe_go & ~kill),
        .ld_valid      (exe_valid),
        .ld_w_en       (exe_w_en),
        .ld_w_addr     (exe_w_addr),
        .ld_data_valid (exe_eff_dv),
        .ld_data       (exe_live),
        .clear         (mem_go | kill),
        .res_valid     (mem_result_valid & ~kill),
        .res_data      (mem_result),
        .valid         (mem_valid),
        .w_en          (mem_w_en),
        .w_addr        (mem_w_addr),
        .data_valid    (mem_dv),
        .data          (mem_data)
    );

    // A flushed MEM record must not slip into WB on the same edge.
    bypass_stage_entry #(.DATA_WD(DATA_WD), .RADDR_WD(RADDR_WD)) u_wb (
        .clk           (clk),
        .resetn        (resetn),
        .load          (mem_go & ~kill),
        .ld_valid      (mem_valid),
        .ld_w_en       (mem_w_en),
        .ld_w_addr     (mem_w_addr),
        .ld_data_valid (mem_eff_dv),
        .ld_data       (mem_live),
        .clear         (wb_go),
        .res_valid     (1'b0),
        .res_data      ('0),
        .valid         (wb_valid),
        .w_en          (wb_w_en),
        .w_addr        (wb_w_addr),
        .data_valid    (wb_dv),
        .data          (wb_data)
    );

    logic exe_tracks, mem_tracks, wb_tracks;
    assign exe_tracks = exe_valid & exe_w_en;
    assign mem_tracks = mem_valid & mem_w_en;
    assign wb_tracks  = wb_valid & wb_w_en;

    assign BY_to_WK_bus = {exe_w_addr, exe_eff_dv, exe_tracks,
                           mem_w_addr, mem_eff_dv, mem_tracks,
                           wb_w_addr,  wb_eff_dv,  wb_tracks};

    // Youngest producer wins: EXE holds the most recent write to a register.
    function automatic fwd_src_e select_src(
        input logic [RADDR_WD-1:0] addr,
        input logic                e_t, input logic [RADDR_WD-1:0] e_a,
        input logic                m_t, input logic [RADDR_WD-1:0] m_a,
        input logic                w_t, input logic [RADDR_WD-1:0] w_a
    );
        if (addr == '0)                 return SRC_NONE;
        else if (e_t && (e_a == addr))  return SRC_EXE;
        else if (m_t && (m_a == addr))  return SRC_MEM;
        else if (w_t && (w_a == addr))  return SRC_WB;
        else                            return SRC_NONE;
    endfunction

    fwd_src_e src1, src2;
    assign src1 = select_src(rd_addr1, exe_tracks, exe_w_addr,
                             mem_tracks, mem_w_addr, wb_tracks, wb_w_addr);
    assign src2 = select_src(rd_addr2, exe_tracks, exe_w_addr,
                             mem_tracks, mem_w_addr, wb_tracks, wb_w_addr);

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        unique case (src1)
            SRC_EXE:  begin fwd_hit1 = 1'b1; fwd_data1 = exe_live; end
            SRC_MEM:  begin fwd_hit1 = 1'b1; fwd_data1 = mem_live; end
            SRC_WB:   begin fwd_hit1 = 1'b1; fwd_data1 = wb_data;  end
            default:  ;
        endcase
        unique case (src2)
            SRC_EXE:  begin fwd_hit2 = 1'b1; fwd_data2 = exe_live; end
            SRC_MEM:  begin fwd_hit2 = 1'b1; fwd_data2 = mem_live; end
            SRC_WB:   begin fwd_hit2 = 1'b1; fwd_data2 = wb_data;  end
            default:  ;
        endcase
    end

endmodule : bypass_tracker

// File: tb/tb_bypass_tracker.sv
// ---------------------------------------------------------------------------
// tb_bypass_tracker
//   Directed bench for bypass_tracker. Expected values are queued as each
//   step is driven and compared on the following falling edge.
//   Flush scenario compiled only with BYPASS_FLUSH_EN.
// ---------------------------------------------------------------------------
`ifndef BY_TO_WK_BUS_WD
`define BY_TO_WK_BUS_WD 21
`endif

module tb_bypass_tracker;

    localparam int DATA_WD  = 32;
    localparam int RADDR_WD = 5;

    typedef enum int {
        SEL_BUS, SEL_EXE, SEL_MEM, SEL_WB,
        SEL_HIT1, SEL_DATA1, SEL_HIT2, SEL_DATA2
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        id_go, id_rf_w_en;
    logic [RADDR_WD-1:0]         id_rf_w_addr;
    logic                        exe_go, mem_go, wb_go;
    logic                        exe_result_valid, mem_result_valid;
    logic [DATA_WD-1:0]          exe_result, mem_result;
    logic [RADDR_WD-1:0]         rd_addr1, rd_addr2;
    logic [`BY_TO_WK_BUS_WD-1:0] BY_to_WK_bus;
    logic                        fwd_hit1, fwd_hit2;
    logic [DATA_WD-1:0]          fwd_data1, fwd_data2;
`ifdef BYPASS_FLUSH_EN
    logic                        flush;
`endif

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bypass_tracker #(.DATA_WD(DATA_WD), .RADDR_WD(RADDR_WD)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_go            (id_go),
        .id_rf_w_en       (id_rf_w_en),
        .id_rf_w_addr     (id_rf_w_addr),
        .exe_go           (exe_go),
        .mem_go           (mem_go),
        .wb_go            (wb_go),
        .exe_result_valid (exe_result_valid),
        .exe_result       (exe_result),
        .mem_result_valid (mem_result_valid),
        .mem_result       (mem_result),
        .rd_addr1         (rd_addr1),
        .rd_addr2         (rd_addr2),
        .BY_to_WK_bus     (BY_to_WK_bus),
        .fwd_hit1         (fwd_hit1),
        .fwd_data1        (fwd_data1),
        .fwd_hit2         (fwd_hit2),
        .fwd_data2        (fwd_data2)
`ifdef BYPASS_FLUSH_EN
        ,
        .flush            (flush)
`endif
    );

    function automatic logic [31:0] observe(sel_e sel);
        case (sel)
            SEL_BUS:   return {11'd0, BY_to_WK_bus};
            SEL_EXE:   return {25'd0, BY_to_WK_bus[20:14]};
            SEL_MEM:   return {25'd0, BY_to_WK_bus[13:7]};
            SEL_WB:    return {25'd0, BY_to_WK_bus[6:0]};
            SEL_HIT1:  return {31'd0, fwd_hit1};
            SEL_DATA1: return fwd_data1;
            SEL_HIT2:  return {31'd0, fwd_hit2};
            default:   return fwd_data2;
        endcase
    endfunction

    // Packs a bus field the way the wake-up logic expects it.
    function automatic logic [31:0] field(int addr, bit dv, bit we);
        logic [4:0] a;
        a = addr[4:0];
        return {25'd0, a, dv, we};
    endfunction

    task automatic expect_val(string tag, sel_e sel, logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) passed++;
            else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the
    // falling edge that follows.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resetn           = 1'b1;
        id_go            = 1'b0;
        id_rf_w_en       = 1'b0;
        id_rf_w_addr     = '0;
        exe_go           = 1'b0;
        mem_go           = 1'b0;
        wb_go            = 1'b0;
        exe_result_valid = 1'b0;
        exe_result       = '0;
        mem_result_valid = 1'b0;
        mem_result       = '0;
        rd_addr1         = '0;
        rd_addr2         = '0;
`ifdef BYPASS_FLUSH_EN
        flush            = 1'b0;
`endif
    endtask

    task automatic issue(int addr);
        id_go        = 1'b1;
        id_rf_w_en   = 1'b1;
        id_rf_w_addr = addr[RADDR_WD-1:0];
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        idle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;

        // Reset with every handshake active: records must still clear.
        resetn = 1'b0;
        issue(5);
        exe_go = 1'b1; mem_go = 1'b1; wb_go = 1'b1;
        rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        tick();
        expect_val("reset_bus",  SEL_BUS,   32'h0);
        expect_val("reset_hit1", SEL_HIT1,  32'h0);
        expect_val("reset_hit2", SEL_HIT2,  32'h0);
        expect_val("reset_d1",   SEL_DATA1, 32'h0);
        tick();

        // ALU chain on r5.
        idle(); issue(5);
        tick();
        idle(); rd_addr1 = 5'd5;
        expect_val("alu_exe_pending", SEL_EXE,  field(5, 0, 1));
        expect_val("alu_hit_pending", SEL_HIT1, 32'h1);
        tick();
        idle(); rd_addr1 = 5'd5;
        exe_result_valid = 1'b1; exe_result = 32'h1234;
        expect_val("alu_exe_live", SEL_EXE,   field(5, 1, 1));
        expect_val("alu_hit1",     SEL_HIT1,  32'h1);
        expect_val("alu_data1",    SEL_DATA1, 32'h1234);
        tick();
        idle(); rd_addr1 = 5'd5;
        expect_val("alu_exe_held",  SEL_EXE,   field(5, 1, 1));
        expect_val("alu_data_held", SEL_DATA1, 32'h1234);
        tick();

        // Load stall on r7.
        do_reset();
        issue(7);
        tick();
        idle(); exe_go = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            idle(); rd_addr2 = 5'd7;
            expect_val("load_mem_wait", SEL_MEM,  field(7, 0, 1));
            expect_val("load_hit_wait", SEL_HIT2, 32'h1);
            tick();
        end
        idle(); rd_addr2 = 5'd7;
        mem_result_valid = 1'b1; mem_result = 32'hCAFE;
        expect_val("load_mem_live", SEL_MEM,   field(7, 1, 1));
        expect_val("load_data2",    SEL_DATA2, 32'hCAFE);
        tick();
        idle(); rd_addr2 = 5'd7;
        expect_val("load_mem_held", SEL_MEM,   field(7, 1, 1));
        expect_val("load_data_held", SEL_DATA2, 32'hCAFE);
        tick();
        idle(); mem_go = 1'b1;
        tick();
        idle(); rd_addr2 = 5'd7;
        expect_val("load_wb_field", SEL_WB,    field(7, 1, 1));
        expect_val("load_mem_empty", SEL_MEM,  32'h0);
        expect_val("load_wb_data",  SEL_DATA2, 32'hCAFE);
        tick();
        idle(); wb_go = 1'b1;
        tick();
        idle(); rd_addr2 = 5'd7;
        expect_val("retired_bus",  SEL_BUS,   32'h0);
        expect_val("retired_hit2", SEL_HIT2,  32'h0);
        expect_val("retired_d2",   SEL_DATA2, 32'h0);
        tick();

        // Priority: r3 in both EXE and MEM; EXE must win.
        do_reset();
        issue(3);
        tick();
        idle(); issue(3); exe_go = 1'b1;
        exe_result_valid = 1'b1; exe_result = 32'hB;
        tick();
        idle(); rd_addr1 = 5'd3; rd_addr2 = 5'd9;
        exe_result_valid = 1'b1; exe_result = 32'hA;
        expect_val("prio_mem_field", SEL_MEM,   field(3, 1, 1));
        expect_val("prio_hit1",      SEL_HIT1,  32'h1);
        expect_val("prio_data1",     SEL_DATA1, 32'hA);
        expect_val("miss_hit2",      SEL_HIT2,  32'h0);
        expect_val("miss_data2",     SEL_DATA2, 32'h0);
        tick();
        idle(); rd_addr1 = 5'd3;
        expect_val("prio_data_held", SEL_DATA1, 32'hA);
        tick();
        idle(); exe_go = 1'b1; mem_go = 1'b1;
        tick();
        idle(); rd_addr1 = 5'd3;
        expect_val("prio_mem_over_wb", SEL_DATA1, 32'hA);
        expect_val("prio_wb_field",    SEL_WB,    field(3, 1, 1));
        tick();

        // Write to r0 is never tracked.
        do_reset();
        issue(0);
        tick();
        idle(); rd_addr1 = 5'd0;
        expect_val("r0_exe_field", SEL_EXE,   32'h0);
        expect_val("r0_hit1",      SEL_HIT1,  32'h0);
        expect_val("r0_data1",     SEL_DATA1, 32'h0);
        tick();

`ifdef BYPASS_FLUSH_EN
        // Flush: EXE = r2, MEM = r4, WB = r6; only WB survives.
        do_reset();
        issue(6);
        tick();
        idle(); issue(4); exe_go = 1'b1;
        exe_result_valid = 1'b1; exe_result = 32'h6;
        tick();
        idle(); issue(2); exe_go = 1'b1; mem_go = 1'b1;
        exe_result_valid = 1'b1; exe_result = 32'h4;
        tick();
        idle(); flush = 1'b1; issue(9);
        exe_result_valid = 1'b1; exe_result = 32'h99;
        tick();
        idle(); rd_addr1 = 5'd6;
        expect_val("flush_bus",   SEL_BUS,   32'h0000_001B);
        expect_val("flush_data1", SEL_DATA1, 32'h6);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_bypass_tracker
